// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the miniLA fetch front end: FSM states and constants.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_S_REQ  = 2'd0,
        FETCH_S_WAIT = 2'd1,
        FETCH_S_OUT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] FETCH_BUBBLE_INST = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch.sv
// Sequential fetch front end: PC register, imem req/gnt/rvalid FSM and redirect handling.
// Optional misaligned-fetch trap (fetch_adef) enabled by defining FETCH_ADEF_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned IMEM_AW  = 32
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        npc,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    output logic               inst_valid,
`ifdef FETCH_ADEF_EN
    output logic               fetch_adef,
`endif
    input  logic               inst_ready
);

    fetch_state_t state, state_n;
    logic [31:0]  pc_n;
    logic [31:0]  inst_n;
    logic         drop, drop_n;
`ifdef FETCH_ADEF_EN
    logic         adef_n;
`endif

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= FETCH_S_REQ;
            pc    <= RESET_PC;
            inst  <= '0;
            drop  <= 1'b0;
`ifdef FETCH_ADEF_EN
            fetch_adef <= 1'b0;
`endif
        end else begin
            state <= state_n;
            pc    <= pc_n;
            inst  <= inst_n;
            drop  <= drop_n;
`ifdef FETCH_ADEF_EN
            fetch_adef <= adef_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        inst_n   = inst;
        drop_n   = drop;
        imem_req = 1'b0;
`ifdef FETCH_ADEF_EN
        adef_n   = fetch_adef;
`endif
        case (state)
            FETCH_S_REQ: begin
                // The request stays low while reset is held even though the FSM rests here.
`ifdef FETCH_ADEF_EN
                imem_req = ~cpu_rst & (pc[1:0] == 2'b00);
`else
                imem_req = ~cpu_rst;
`endif
                if (flush) begin
                    pc_n = flush_pc;
                end
`ifdef FETCH_ADEF_EN
                else if (pc[1:0] != 2'b00) begin
                    state_n = FETCH_S_OUT;
                    inst_n  = FETCH_BUBBLE_INST;
                    adef_n  = 1'b1;
                end
`endif
                else if (imem_gnt) begin
                    state_n = FETCH_S_WAIT;
                end
            end
            FETCH_S_WAIT: begin
                if (flush) begin
                    pc_n = flush_pc;
                    if (imem_rvalid) begin
                        drop_n  = 1'b0;
                        state_n = FETCH_S_REQ;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = FETCH_S_REQ;
                    end else begin
                        inst_n  = imem_rdata;
                        state_n = FETCH_S_OUT;
                    end
                end
            end
            FETCH_S_OUT: begin
                if (flush) begin
                    pc_n    = flush_pc;
                    state_n = FETCH_S_REQ;
`ifdef FETCH_ADEF_EN
                    adef_n  = 1'b0;
`endif
                end else if (inst_ready) begin
                    pc_n    = npc;
                    state_n = FETCH_S_REQ;
`ifdef FETCH_ADEF_EN
                    adef_n  = 1'b0;
`endif
                end
            end
            default: state_n = FETCH_S_REQ;
        endcase
    end

    assign imem_addr  = pc[IMEM_AW-1:0];
    assign inst_valid = (state == FETCH_S_OUT);

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: transaction-level model plus directed scenarios.
// Define FETCH_ADEF_EN to exercise the misaligned-fetch trap.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_ADEF_EN
    localparam bit ADEF = 1'b1;
`else
    localparam bit ADEF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] npc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
`ifdef FETCH_ADEF_EN
    logic        fetch_adef;
`endif

    logic        npc_auto;
    logic [31:0] npc_drv;
    assign npc = npc_auto ? pc + 32'd4 : npc_drv;

    pc_fetch #(.RESET_PC(RST_PC), .IMEM_AW(32)) dut (
        .cpu_clk(clk), .cpu_rst(cpu_rst), .npc(npc), .flush(flush), .flush_pc(flush_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc), .inst(inst),
        .inst_valid(inst_valid),
`ifdef FETCH_ADEF_EN
        .fetch_adef(fetch_adef),
`endif
        .inst_ready(inst_ready));

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cycle  = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + 32'h0000_0011;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Imem responder: grant after gnt_delay waiting cycles, data rv_lat cycles after grant.
    int unsigned gnt_delay, rv_lat;
    bit          pend;
    logic [31:0] pend_addr, gnt_addr;
    int unsigned lat, wait_cnt;

    always @(posedge clk) begin
        #1;
        if (imem_gnt && !flush && !cpu_rst) begin
            pend = 1'b1; pend_addr = gnt_addr; lat = rv_lat;
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        if (cpu_rst) begin
            pend = 1'b0; wait_cnt = 0;
        end else begin
            if (pend) begin
                if (lat <= 1) begin
                    imem_rvalid = 1'b1; imem_rdata = memfn(pend_addr); pend = 1'b0;
                end else lat--;
            end
            if (imem_req && !pend) begin
                if (wait_cnt >= gnt_delay) begin
                    imem_gnt = 1'b1; gnt_addr = imem_addr; wait_cnt = 0;
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    // Transaction model: m_out = request granted, awaiting data; m_stale = that data is void.
    logic [31:0] m_pc, m_inst;
    bit          m_have, m_out, m_stale, m_adef;
    logic [31:0] glog_addr[$];
    int unsigned glog_cyc[$];
    int unsigned glog_run[$];
    int unsigned req_run = 0;
    int unsigned valid_cnt = 0;

    always @(negedge clk) begin
        cycle++;
        if (cpu_rst) begin
            chk("rst_pc", pc, RST_PC);
            chk("rst_inst", inst, 32'h0);
            chk("rst_valid", {31'b0, inst_valid}, 32'h0);
            chk("rst_req", {31'b0, imem_req}, 32'h0);
            m_pc = RST_PC; m_inst = '0; m_have = 0; m_out = 0; m_stale = 0; m_adef = 0;
            req_run = 0;
        end else begin
            bit exp_req;
            exp_req = !m_have && !m_out && !(ADEF && m_pc[1:0] != 2'b00);
            chk("pc", pc, m_pc);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            if (m_have) chk("inst", inst, m_inst);
`ifdef FETCH_ADEF_EN
            chk("fetch_adef", {31'b0, fetch_adef}, {31'b0, m_adef});
`endif
            if (inst_valid) valid_cnt++;
            if (imem_req && !flush) req_run++; else req_run = 0;
            if (imem_req && imem_gnt && !flush) begin
                glog_addr.push_back(imem_addr); glog_cyc.push_back(cycle); glog_run.push_back(req_run);
                req_run = 0;
            end
            if (flush) begin
                if (m_out) begin
                    if (imem_rvalid) begin m_out = 0; m_stale = 0; end
                    else m_stale = 1;
                end
                m_pc = flush_pc; m_have = 0; m_adef = 0;
            end else if (m_have) begin
                if (inst_ready) begin m_pc = npc; m_have = 0; m_adef = 0; end
            end else if (m_out) begin
                if (imem_rvalid) begin
                    m_out = 0;
                    if (!m_stale) begin m_have = 1; m_inst = memfn(m_pc); end
                    m_stale = 0;
                end
            end else if (ADEF && m_pc[1:0] != 2'b00) begin
                m_have = 1; m_inst = 32'h0; m_adef = 1;
            end else if (imem_gnt) begin
                m_out = 1;
            end
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int unsigned n = 0;
        while (!inst_valid && n < 40) begin cyc(1); n++; end
        chk(name, {31'b0, inst_valid}, 32'h1);
    endtask

    task automatic wait_grant(input string name, output logic [31:0] addr, output int unsigned run);
        int unsigned base = glog_addr.size();
        int unsigned n = 0;
        while (glog_addr.size() <= base && n < 40) begin cyc(1); n++; end
        chk({name, "_seen"}, {31'b0, glog_addr.size() > base}, 32'h1);
        addr = (glog_addr.size() > base) ? glog_addr[base] : 32'hxxxx_xxxx;
        run  = (glog_addr.size() > base) ? glog_run[base] : 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int unsigned run, vbase;
        cpu_rst = 1'b1; flush = 1'b0; flush_pc = '0; inst_ready = 1'b1;
        npc_auto = 1'b1; npc_drv = '0; gnt_delay = 0; rv_lat = 1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        cyc(2);
        cpu_rst = 1'b0;

        // Zero-wait streaming, npc = pc + 4
        cyc(12);
        chk("stream_cnt_ok", {31'b0, glog_addr.size() >= 3}, 32'h1);
        if (glog_addr.size() >= 3) begin
            chk("stream_a0", glog_addr[0], 32'h0);
            chk("stream_a1", glog_addr[1], 32'h4);
            chk("stream_a2", glog_addr[2], 32'h8);
            chk("stream_gap1", glog_cyc[1] - glog_cyc[0], 32'd3);
            chk("stream_gap2", glog_cyc[2] - glog_cyc[1], 32'd3);
        end
        inst_ready = 1'b0; npc_auto = 1'b0;
        wait_valid("park1");

        // Delayed grant: request held for 4 waiting cycles plus the grant cycle
        gnt_delay = 4;
        flush = 1'b1; flush_pc = 32'h0;
        cyc(1);
        flush = 1'b0; vbase = valid_cnt;
        wait_grant("gdly", a, run);
        chk("gdly_addr", a, 32'h0);
        chk("gdly_run", run, 32'd5);
        chk("gdly_novalid", valid_cnt - vbase, 32'd0);
        gnt_delay = 0;
        wait_valid("gdly_valid");
        chk("gdly_inst", inst, memfn(32'h0));

        // Stall in OUT with npc toggling; accept takes the npc present then
        for (int i = 0; i < 5; i++) begin
            npc_drv = (i % 2 == 0) ? 32'h300 : 32'h304;
            cyc(1);
        end
        chk("stall_pc_held", pc, 32'h0);
        npc_drv = 32'h1234_5678; inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0; npc_drv = 32'hDEAD_0000;
        chk("stall_pc_new", pc, 32'h1234_5678);
        wait_valid("stall_valid");

        // Flush while waiting for data: response dropped, refetch at flush_pc
        rv_lat = 3; npc_drv = 32'h600; inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0;
        wait_grant("wflush_pre", a, run);
        chk("wflush_pre_addr", a, 32'h600);
        flush = 1'b1; flush_pc = 32'h1C00_0000; vbase = valid_cnt;
        cyc(1);
        flush = 1'b0;
        wait_grant("wflush", a, run);
        chk("wflush_addr", a, 32'h1C00_0000);
        chk("wflush_novalid", valid_cnt - vbase, 32'd0);
        rv_lat = 1;
        wait_valid("wflush_valid");
        chk("wflush_inst", inst, memfn(32'h1C00_0000));

        // Flush coincident with accept: flush wins
        npc_drv = 32'h40; flush_pc = 32'h80; flush = 1'b1; inst_ready = 1'b1;
        cyc(1);
        flush = 1'b0; inst_ready = 1'b0;
        chk("facc_pc", pc, 32'h80);
        wait_valid("facc_valid");
        chk("facc_inst", inst, memfn(32'h80));

        // Flush coincident with a grant in REQ: grant abandoned, reissue at flush_pc
        npc_drv = 32'h700; inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0; flush = 1'b1; flush_pc = 32'h900;
        cyc(1);
        flush = 1'b0;
        wait_grant("rflush", a, run);
        chk("rflush_addr", a, 32'h900);
        wait_valid("rflush_valid");

        // Reset in the middle of a transaction
        rv_lat = 4; npc_drv = 32'h800; inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0;
        cyc(2);
        cpu_rst = 1'b1;
        cyc(2);
        cpu_rst = 1'b0; rv_lat = 1;
        wait_grant("mrst", a, run);
        chk("mrst_addr", a, RST_PC);
        wait_valid("mrst_valid");

        // Misaligned next PC
        npc_drv = 32'h102; inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0;
`ifdef FETCH_ADEF_EN
        cyc(1);
        chk("adef_noreq", {31'b0, imem_req}, 32'h0);
        wait_valid("adef_valid");
        chk("adef_inst", inst, 32'h0);
        chk("adef_flag", {31'b0, fetch_adef}, 32'h1);
        flush = 1'b1; flush_pc = 32'h104;
        cyc(1);
        flush = 1'b0;
        chk("adef_clear", {31'b0, fetch_adef}, 32'h0);
        wait_valid("adef_after");
`else
        wait_grant("misal", a, run);
        chk("misal_addr", a, 32'h102);
        wait_valid("misal_valid");
        chk("misal_inst", inst, memfn(32'h102));
`endif
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Sequential fetch front end of the miniLA core. Sits directly downstream of the next-PC unit: holds the architectural PC and fetches the instruction at that PC from instruction memory.
- Presents the fetched instruction to decode/execute. Loads the next-PC value into the PC once that instruction is accepted.
- Imem uses a req/gnt request phase and an rvalid response phase with variable latency.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 32, width of imem_addr. The low IMEM_AW bits of pc are driven.

Ports:
- cpu_clk  in  1  core clock; all state updates on its rising edge
- cpu_rst  in  1  asynchronous, active-high reset
- npc  in  32  next PC from the next-PC unit; sampled only on an accept
- flush  in  1  redirect request (exception/ertn); overrides npc
- flush_pc  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  IMEM_AW  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- pc  out  32  PC of the current instruction; feeds the next-PC unit
- inst  out  32  fetched instruction
- inst_valid  out  1  inst is valid for pc
- inst_ready  in  1  downstream accepts inst this cycle

Behaviour:
- Reset (async, while cpu_rst=1):
  - pc=RESET_PC, state=S_REQ, inst=0, inst_valid=0, imem_req=0, drop=0.
  - imem_req asserts from the first cycle after reset deassertion.
- FSM states: S_REQ, S_WAIT, S_OUT.
- S_REQ:
  - imem_req=1, imem_addr=pc[IMEM_AW-1:0].
  - imem_gnt=1 -> S_WAIT. Otherwise hold; req and addr stay stable.
- S_WAIT:
  - imem_req=0.
  - imem_rvalid=1 and drop=0 -> inst<=imem_rdata, go S_OUT.
  - imem_rvalid=1 and drop=1 -> discard the data, clear drop, go S_REQ.
  - Response arrives no earlier than the cycle after gnt.
- S_OUT:
  - inst_valid=1; inst and pc held stable until accept.
  - Accept = inst_valid & inst_ready: pc<=npc, inst_valid<=0, go S_REQ.
  - Fetch-to-fetch minimum: 3 cycles (REQ with gnt, WAIT with rvalid, OUT with ready).
- flush has priority over everything, in every state:
  - S_REQ or S_OUT: pc<=flush_pc, inst_valid<=0, go S_REQ. A gnt in the same cycle is ignored; imem must tolerate the abandoned request, and the next REQ reissues at flush_pc.
  - S_WAIT: pc<=flush_pc, drop<=1, stay in S_WAIT until rvalid.
  - flush coincident with rvalid in S_WAIT: the data is dropped, drop is not set, go S_REQ.
  - flush coincident with accept: the flush wins and npc is ignored.
- inst_valid never asserts for a dropped response.
- pc changes only on accept, flush, or reset.
- npc is used as-is; no +4 or alignment arithmetic in this block except the optional check below.
- Reset asserted mid-transaction: abandon the transaction. The imem side must clear with the same reset.

Optional Feature:
- Macro: FETCH_ADEF_EN.
- When defined:
  - Adds output fetch_adef (1 bit, reset 0).
  - On entering S_REQ with pc[1:0]!=2'b00, no imem request is issued. The block goes directly to S_OUT with inst=32'h0 and fetch_adef=1.
  - fetch_adef clears on accept or flush.
- When undefined: no port; misaligned pc is fetched as-is.

Decomposition:
- Shared defines header gains:
  - FSM state encodings (FETCH_S_REQ/WAIT/OUT, 2-bit).
  - RESET_PC default constant.
  - The 32'h0 bubble instruction constant.
- No sub-module is needed. The FSM, PC register and drop flag form one block.

Test Plan:
- Zero-wait imem (gnt same cycle as req, rvalid next cycle), inst_ready=1, npc=pc+4 -> imem_addr 0x0, 0x4, 0x8 at 3-cycle spacing; inst matches rdata.
- gnt delayed 4 cycles -> imem_req and imem_addr=0x0 held stable; inst_valid=0 throughout.
- inst_ready=0 for 5 cycles in S_OUT, npc toggling -> inst and pc held; pc takes the npc value present at the accept cycle.
- flush (flush_pc=0x1C000000) in S_WAIT, rvalid 2 cycles later -> response dropped, next imem_addr=0x1C000000, no inst_valid pulse.
- flush and accept in the same cycle, npc=0x40, flush_pc=0x80 -> pc=0x80.
- FETCH_ADEF_EN defined, npc=0x102 -> no imem_req; inst_valid=1, inst=0, fetch_adef=1.
